// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder/subtractor that steps one 4-bit ripple-carry slice
// across the operands, LSB nibble first, with the inter-nibble carry held in a register.

module fa_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  // Four-bit ripple-carry chain
  always_comb begin
    logic cy_s;
    cy_s = c_in;
    s    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ cy_s;
      cy_s = (a[i] & b[i]) | (cy_s & (a[i] ^ b[i]));
    end
    c_out = cy_s;
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  input  logic                   sub,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   c_out,
  output logic                   ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    ps_r;
  logic [W-1:0]    ps_nxt_s;
  logic [W-1:0]    s_r;
  logic            carry_r;
  logic [CW-1:0]   cnt_r;
  logic            a_msb_r;
  logic            b_msb_r;
  logic            c_out_r;
  logic            ovf_r;
  logic            accept_s;
  logic            last_s;
  logic [3:0]      slice_sum_s;
  logic            slice_co_s;
  logic            start_ready_s;
  logic            busy_s;
  logic            done_s;

  assign accept_s = start_valid && (state_r == IDLE);
  assign last_s   = (state_r == RUN) && (cnt_r == CW'(NIBBLES - 1));
  // Each new sum nibble enters at the top, so after NIBBLES steps it sits in place
  assign ps_nxt_s = {slice_sum_s, ps_r[W-1:4]};

  fa_4 u_slice (
    .a     (a_sh_r[3:0]),
    .b     (b_sh_r[3:0]),
    .c_in  (carry_r),
    .s     (slice_sum_s),
    .c_out (slice_co_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake and status decode
  always_comb begin
    start_ready_s = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      IDLE:    start_ready_s = 1'b1;
      RUN:     busy_s        = 1'b1;
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: start_ready_s = 1'b0;
    endcase
  end

  // Operand shift registers, carry chain and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= {W{1'b0}};
      b_sh_r  <= {W{1'b0}};
      ps_r    <= {W{1'b0}};
      s_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched here
      a_sh_r  <= a;
      b_sh_r  <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : c_in;
      cnt_r   <= {CW{1'b0}};
      a_msb_r <= a[W-1];
      b_msb_r <= sub ? ~b[W-1] : b[W-1];
    end else if (state_r == RUN) begin
      a_sh_r  <= {4'b0000, a_sh_r[W-1:4]};
      b_sh_r  <= {4'b0000, b_sh_r[W-1:4]};
      ps_r    <= ps_nxt_s;
      carry_r <= slice_co_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        s_r     <= ps_nxt_s;
        c_out_r <= slice_co_s;
        ovf_r   <= (a_msb_r == b_msb_r) && (ps_nxt_s[W-1] != a_msb_r);
      end
    end
  end

  assign s           = s_r;
  assign c_out       = c_out_r;
  assign ovf         = ovf_r;
  assign start_ready = start_ready_s;
  assign busy        = busy_s;
  assign done        = done_s;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): directed vectors push
// expected results, an independent monitor checks them on every done pulse.

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          edge_n;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          edge_cnt = 0;
  int          last_accept = 0;
  logic [17:0] last_res = 18'h0;
  int          busy_cnt = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .s(s), .c_out(c_out), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares results on done, checks latency, busy length and output hold
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_res = 18'h0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      else      busy_cnt = 0;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result_s", {16'h0, s}, {16'h0, e.s});
          chk("result_c_out", {31'h0, c_out}, {31'h0, e.c});
          chk("result_ovf", {31'h0, ovf}, {31'h0, e.o});
          chk("done_latency", edge_cnt, e.edge_n + 4);
          chk("busy_cycles", busy_cnt, 32'd5);
          last_res = {e.s, e.c, e.o};
        end
      end else begin
        chk("output_hold", {14'h0, s, c_out, ovf}, {14'h0, last_res});
      end
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input logic tsub, input logic [15:0] es, input logic ec,
                       input logic eo, input bit push);
    int w = 0;
    @(negedge clk);
    while (!start_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!start_ready) chk("ready_timeout", 32'd0, 32'd1);
    a = ta; b = tb_v; c_in = tc; sub = tsub; start_valid = 1'b1;
    last_accept = edge_cnt + 1;
    if (push) q.push_back('{es, ec, eo, edge_cnt + 1});
    @(negedge clk);
    start_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'b1; sub = 1'b1;
  endtask

  initial begin
    logic [15:0] sa [2];
    logic [15:0] sb [2];
    exp_t        se [2];
    int          n_acc;
    int          prev_acc;
    int          w;

    rst = 1'b1; start_valid = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_s", {16'h0, s}, 32'h0);
    chk("reset_c_out", {31'h0, c_out}, 32'h0);
    chk("reset_ovf", {31'h0, ovf}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_ready", {31'h0, start_ready}, 32'h1);

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);

    // Continuous start_valid with operands churning every cycle
    sa[0] = 16'h0F0F; sb[0] = 16'h00F1; se[0] = '{16'h1000, 1'b0, 1'b0, 0};
    sa[1] = 16'h9000; sb[1] = 16'h9000; se[1] = '{16'h2000, 1'b1, 1'b1, 0};
    w = 0;
    @(negedge clk);
    while (!start_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_acc = 0; prev_acc = 0;
    c_in = 1'b0; sub = 1'b0; start_valid = 1'b1;
    for (int k = 0; k < 20 && n_acc < 2; k++) begin
      if (k > 0) @(negedge clk);
      if (start_ready) begin
        a = sa[n_acc]; b = sb[n_acc];
        se[n_acc].edge_n = edge_cnt + 1;
        q.push_back(se[n_acc]);
        if (n_acc == 1) chk("accept_spacing", edge_cnt + 1 - prev_acc, 32'd6);
        prev_acc = edge_cnt + 1;
        n_acc++;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
    end
    chk("stream_accepts", n_acc, 32'd2);
    @(negedge clk);
    start_valid = 1'b0;
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end

    // Abort an operation with an asynchronous reset mid-RUN
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_s", {16'h0, s}, 32'h0);
    chk("abort_c_out", {31'h0, c_out}, 32'h0);
    chk("abort_ovf", {31'h0, ovf}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'h0, start_ready}, 32'h1);
    repeat (8) @(negedge clk);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("queue_drained", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
